rob_retire: RTL and testbench

//  Reorder buffer plus in-order retire stage for the Tomasulo core. The dispatch side allocates one entry
//  per cycle at the tail and receives a ROB tag. Functional units write results back by tag. This block

---
 rtl/rob_retire.sv | 116 +++++++++++
 tb/tb_rob_retire.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rob_retire.sv
// Reorder buffer with in-order, single-wide retire. Dispatch allocates at the tail,
// functional units complete entries by tag, and the head retires once it is done.
module rob_retire #(
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3,
  parameter int OPC_W  = 4,
  parameter int REG_W  = 4,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_alloc_valid,
  input  logic [OPC_W-1:0]  i_alloc_opcode,
  input  logic [REG_W-1:0]  i_alloc_dest,
  output logic              o_alloc_ready,
  output logic [PTR_W-1:0]  o_alloc_tag,
  input  logic              i_wb_valid,
  input  logic [PTR_W-1:0]  i_wb_tag,
  input  logic [DATA_W-1:0] i_wb_value,
  output logic              o_commit_valid,
  output logic [PTR_W-1:0]  o_commit_tag,
  output logic [OPC_W-1:0]  o_commit_opcode,
  output logic [REG_W-1:0]  o_commit_dest,
  output logic [DATA_W-1:0] o_commit_value,
  output logic              o_commit_rf_we,
  output logic              o_commit_st,
  output logic [PTR_W:0]    o_count,
  output logic              o_empty
);

  localparam logic [OPC_W-1:0] OPC_STORE = OPC_W'(4);
  localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W+1)'(DEPTH);

  logic [DEPTH-1:0]  r_busy, r_done;
  logic [OPC_W-1:0]  r_opc  [DEPTH];
  logic [REG_W-1:0]  r_dest [DEPTH];
  logic [DATA_W-1:0] r_val  [DEPTH];
  logic [PTR_W-1:0]  r_head, r_tail;
  logic [PTR_W:0]    r_count;

  logic              r_cv;
  logic [PTR_W-1:0]  r_ctag;
  logic [OPC_W-1:0]  r_copc;
  logic [REG_W-1:0]  r_cdest;
  logic [DATA_W-1:0] r_cval;

  logic w_alloc, w_retire, w_wb_hit;

  // Readiness uses pre-edge count, so a full ROB refuses even while retiring.
  assign o_alloc_ready = (r_count != CNT_FULL);
  assign o_alloc_tag   = r_tail;
  assign o_count       = r_count;
  assign o_empty       = (r_count == '0);

  assign w_alloc  = i_alloc_valid && o_alloc_ready;
  assign w_retire = r_busy[r_head] && r_done[r_head];
  assign w_wb_hit = i_wb_valid && r_busy[i_wb_tag];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy  <= '0;
      r_done  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_cv    <= 1'b0;
      r_ctag  <= '0;
      r_copc  <= '0;
      r_cdest <= '0;
      r_cval  <= '0;
    end else begin
      if (w_wb_hit) r_done[i_wb_tag] <= 1'b1;
      // Retire clears after writeback so a late writeback cannot revive a freed slot.
      if (w_retire) begin
        r_busy[r_head] <= 1'b0;
        r_done[r_head] <= 1'b0;
        r_head         <= r_head + 1'b1;
      end
      if (w_alloc) begin
        r_busy[r_tail] <= 1'b1;
        r_done[r_tail] <= 1'b0;
        r_tail         <= r_tail + 1'b1;
      end
      case ({w_alloc, w_retire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_cv <= w_retire;
      if (w_retire) begin
        r_ctag  <= r_head;
        r_copc  <= r_opc[r_head];
        r_cdest <= r_dest[r_head];
        r_cval  <= r_val[r_head];
      end
    end
  end

  // Payload storage carries no reset; busy/done qualify every use.
  always_ff @(posedge i_clk) begin
    if (w_wb_hit) r_val[i_wb_tag] <= i_wb_value;
    if (w_alloc) begin
      r_opc[r_tail]  <= i_alloc_opcode;
      r_dest[r_tail] <= i_alloc_dest;
    end
  end

  assign o_commit_valid  = r_cv;
  assign o_commit_tag    = r_ctag;
  assign o_commit_opcode = r_copc;
  assign o_commit_dest   = r_cdest;
  assign o_commit_value  = r_cval;
  assign o_commit_rf_we  = r_cv && (r_copc != OPC_STORE);
  assign o_commit_st     = r_cv && (r_copc == OPC_STORE);

endmodule

// File: tb/tb_rob_retire.sv
// Directed bench for rob_retire: a per-cycle vector table plus hand-written
// sequences for fill/overflow, full-with-retire and mid-flight reset.
module tb_rob_retire;

  logic        clk = 1'b0;
  logic        rst, alloc_valid, wb_valid;
  logic [3:0]  alloc_opcode, alloc_dest;
  logic [2:0]  wb_tag;
  logic [15:0] wb_value;
  logic        alloc_ready, commit_valid, commit_rf_we, commit_st, empty;
  logic [2:0]  alloc_tag, commit_tag;
  logic [3:0]  commit_opcode, commit_dest, count;
  logic [15:0] commit_value;

  int checks = 0;
  int errors = 0;

  rob_retire dut (
    .i_clk(clk), .i_rst(rst),
    .i_alloc_valid(alloc_valid), .i_alloc_opcode(alloc_opcode), .i_alloc_dest(alloc_dest),
    .o_alloc_ready(alloc_ready), .o_alloc_tag(alloc_tag),
    .i_wb_valid(wb_valid), .i_wb_tag(wb_tag), .i_wb_value(wb_value),
    .o_commit_valid(commit_valid), .o_commit_tag(commit_tag), .o_commit_opcode(commit_opcode),
    .o_commit_dest(commit_dest), .o_commit_value(commit_value),
    .o_commit_rf_we(commit_rf_we), .o_commit_st(commit_st),
    .o_count(count), .o_empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, av;
    logic [3:0]  opc, dest;
    logic        wv;
    logic [2:0]  wt;
    logic [15:0] wval;
    logic        e_ready;
    logic [2:0]  e_tag;
    logic        e_cv;
    logic [2:0]  e_ctag;
    logic [3:0]  e_copc, e_cdest;
    logic [15:0] e_cval;
    logic [3:0]  e_cnt;
  } vec_t;

  localparam int NV = 32;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic r, input logic av, input logic [3:0] opc,
                              input logic [3:0] dest, input logic wv, input logic [2:0] wt,
                              input logic [15:0] wval, input logic e_ready, input logic [2:0] e_tag,
                              input logic e_cv, input logic [2:0] e_ctag, input logic [3:0] e_copc,
                              input logic [3:0] e_cdest, input logic [15:0] e_cval,
                              input logic [3:0] e_cnt);
    vec_t v;
    v.rst = r; v.av = av; v.opc = opc; v.dest = dest; v.wv = wv; v.wt = wt; v.wval = wval;
    v.e_ready = e_ready; v.e_tag = e_tag; v.e_cv = e_cv; v.e_ctag = e_ctag;
    v.e_copc = e_copc; v.e_cdest = e_cdest; v.e_cval = e_cval; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic av, input logic [3:0] opc, input logic [3:0] dest,
                       input logic wv, input logic [2:0] wt, input logic [15:0] wval);
    rst = r; alloc_valid = av; alloc_opcode = opc; alloc_dest = dest;
    wb_valid = wv; wb_tag = wt; wb_value = wval;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 4'h0, 4'h0, 0, 3'd0, 16'h0);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    //              rst av opc dest wv wt wval     rdy tag cv ctag copc cdest cval   cnt
    vecs[0]  = mk(1, 0, 4'h0, 4'h0, 0, 3'd0, 16'h0000, 1, 3'd0, 0, 3'd0, 4'h0, 4'h0, 16'h0000, 4'd0);
    vecs[1]  = mk(0, 1, 4'h1, 4'h3, 0, 3'd0, 16'h0000, 1, 3'd1, 0, 3'd0, 4'h0, 4'h0, 16'h0000, 4'd1);
    vecs[2]  = mk(0, 0, 4'h0, 4'h0, 1, 3'd0, 16'h0025, 1, 3'd1, 0, 3'd0, 4'h0, 4'h0, 16'h0000, 4'd1);
    vecs[3]  = mk(0, 0, 4'h0, 4'h0, 0, 3'd0, 16'h0000, 1, 3'd1, 1, 3'd0, 4'h1, 4'h3, 16'h0025, 4'd0);
    vecs[4]  = mk(0, 0, 4'h0, 4'h0, 0, 3'd0, 16'h0000, 1, 3'd1, 0, 3'd0, 4'h0, 4'h0, 16'h0000, 4'd0);
    // store retires: st strobe, no rf write
    vecs[5]  = mk(0, 1, 4'h4, 4'h0, 0, 3'd0, 16'h0000, 1, 3'd2, 0, 3'd0, 4'h0, 4'h0, 16'h0000, 4'd1);
    vecs[6]  = mk(0, 0, 4'h0, 4'h0, 1, 3'd1, 16'h00AA, 1, 3'd2, 0, 3'd0, 4'h0, 4'h0, 16'h0000, 4'd1);
    vecs[7]  = mk(0, 0, 4'h0, 4'h0, 0, 3'd0, 16'h0000, 1, 3'd2, 1, 3'd1, 4'h4, 4'h0, 16'h00AA, 4'd0);
    vecs[8]  = mk(0, 0, 4'h0, 4'h0, 0, 3'd0, 16'h0000, 1, 3'd2, 0, 3'd0, 4'h0, 4'h0, 16'h0000, 4'd0);
    // out-of-order completion waits for head
    vecs[9]  = mk(1, 0, 4'h0, 4'h0, 0, 3'd0, 16'h0000, 1, 3'd0, 0, 3'd0, 4'h0, 4'h0, 16'h0000, 4'd0);
    vecs[10] = mk(0, 1, 4'h0, 4'h5, 0, 3'd0, 16'h0000, 1, 3'd1, 0, 3'd0, 4'h0, 4'h0, 16'h0000, 4'd1);
    vecs[11] = mk(0, 1, 4'h2, 4'h6, 0, 3'd0, 16'h0000, 1, 3'd2, 0, 3'd0, 4'h0, 4'h0, 16'h0000, 4'd2);
    vecs[12] = mk(0, 1, 4'h3, 4'h7, 0, 3'd0, 16'h0000, 1, 3'd3, 0, 3'd0, 4'h0, 4'h0, 16'h0000, 4'd3);
    vecs[13] = mk(0, 0, 4'h0, 4'h0, 1, 3'd2, 16'h0202, 1, 3'd3, 0, 3'd0, 4'h0, 4'h0, 16'h0000, 4'd3);
    vecs[14] = mk(0, 0, 4'h0, 4'h0, 1, 3'd1, 16'h0101, 1, 3'd3, 0, 3'd0, 4'h0, 4'h0, 16'h0000, 4'd3);
    vecs[15] = mk(0, 0, 4'h0, 4'h0, 0, 3'd0, 16'h0000, 1, 3'd3, 0, 3'd0, 4'h0, 4'h0, 16'h0000, 4'd3);
    vecs[16] = mk(0, 0, 4'h0, 4'h0, 0, 3'd0, 16'h0000, 1, 3'd3, 0, 3'd0, 4'h0, 4'h0, 16'h0000, 4'd3);
    vecs[17] = mk(0, 0, 4'h0, 4'h0, 0, 3'd0, 16'h0000, 1, 3'd3, 0, 3'd0, 4'h0, 4'h0, 16'h0000, 4'd3);
    vecs[18] = mk(0, 0, 4'h0, 4'h0, 1, 3'd0, 16'h0100, 1, 3'd3, 0, 3'd0, 4'h0, 4'h0, 16'h0000, 4'd3);
    vecs[19] = mk(0, 0, 4'h0, 4'h0, 0, 3'd0, 16'h0000, 1, 3'd3, 1, 3'd0, 4'h0, 4'h5, 16'h0100, 4'd2);
    vecs[20] = mk(0, 0, 4'h0, 4'h0, 0, 3'd0, 16'h0000, 1, 3'd3, 1, 3'd1, 4'h2, 4'h6, 16'h0101, 4'd1);
    vecs[21] = mk(0, 0, 4'h0, 4'h0, 0, 3'd0, 16'h0000, 1, 3'd3, 1, 3'd2, 4'h3, 4'h7, 16'h0202, 4'd0);
    vecs[22] = mk(0, 0, 4'h0, 4'h0, 0, 3'd0, 16'h0000, 1, 3'd3, 0, 3'd0, 4'h0, 4'h0, 16'h0000, 4'd0);
    // writeback to idle slot ignored; writeback overwrite keeps last value
    vecs[23] = mk(0, 0, 4'h0, 4'h0, 1, 3'd5, 16'h0555, 1, 3'd3, 0, 3'd0, 4'h0, 4'h0, 16'h0000, 4'd0);
    vecs[24] = mk(0, 1, 4'h1, 4'h9, 0, 3'd0, 16'h0000, 1, 3'd4, 0, 3'd0, 4'h0, 4'h0, 16'h0000, 4'd1);
    vecs[25] = mk(0, 1, 4'h1, 4'hA, 1, 3'd4, 16'h1111, 1, 3'd5, 0, 3'd0, 4'h0, 4'h0, 16'h0000, 4'd2);
    vecs[26] = mk(0, 0, 4'h0, 4'h0, 1, 3'd4, 16'h2222, 1, 3'd5, 0, 3'd0, 4'h0, 4'h0, 16'h0000, 4'd2);
    vecs[27] = mk(0, 0, 4'h0, 4'h0, 1, 3'd4, 16'h3333, 1, 3'd5, 0, 3'd0, 4'h0, 4'h0, 16'h0000, 4'd2);
    vecs[28] = mk(0, 0, 4'h0, 4'h0, 1, 3'd3, 16'h0333, 1, 3'd5, 0, 3'd0, 4'h0, 4'h0, 16'h0000, 4'd2);
    vecs[29] = mk(0, 0, 4'h0, 4'h0, 0, 3'd0, 16'h0000, 1, 3'd5, 1, 3'd3, 4'h1, 4'h9, 16'h0333, 4'd1);
    vecs[30] = mk(0, 0, 4'h0, 4'h0, 0, 3'd0, 16'h0000, 1, 3'd5, 1, 3'd4, 4'h1, 4'hA, 16'h3333, 4'd0);
    vecs[31] = mk(0, 0, 4'h0, 4'h0, 0, 3'd0, 16'h0000, 1, 3'd5, 0, 3'd0, 4'h0, 4'h0, 16'h0000, 4'd0);

    #2;
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].av, vecs[i].opc, vecs[i].dest, vecs[i].wv, vecs[i].wt, vecs[i].wval);
      tick();
      chk($sformatf("v%0d alloc_ready", i), 16'(alloc_ready), 16'(vecs[i].e_ready));
      chk($sformatf("v%0d alloc_tag", i), 16'(alloc_tag), 16'(vecs[i].e_tag));
      chk($sformatf("v%0d commit_valid", i), 16'(commit_valid), 16'(vecs[i].e_cv));
      chk($sformatf("v%0d rf_we", i), 16'(commit_rf_we), 16'(vecs[i].e_cv && vecs[i].e_copc != 4'h4));
      chk($sformatf("v%0d st", i), 16'(commit_st), 16'(vecs[i].e_cv && vecs[i].e_copc == 4'h4));
      chk($sformatf("v%0d count", i), 16'(count), 16'(vecs[i].e_cnt));
      chk($sformatf("v%0d empty", i), 16'(empty), 16'(vecs[i].e_cnt == 4'd0));
      if (vecs[i].e_cv) begin
        chk($sformatf("v%0d commit_tag", i), 16'(commit_tag), 16'(vecs[i].e_ctag));
        chk($sformatf("v%0d commit_opc", i), 16'(commit_opcode), 16'(vecs[i].e_copc));
        chk($sformatf("v%0d commit_dest", i), 16'(commit_dest), 16'(vecs[i].e_cdest));
        chk($sformatf("v%0d commit_value", i), commit_value, vecs[i].e_cval);
      end
    end

    // Fill all 8 entries, then a refused 9th allocation.
    drive(1, 0, 4'h0, 4'h0, 0, 3'd0, 16'h0); tick();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fill%0d tag", i), 16'(alloc_tag), 16'(i));
      drive(0, 1, 4'h1, 4'(i + 1), 0, 3'd0, 16'h0); tick();
      chk($sformatf("fill%0d count", i), 16'(count), 16'(i + 1));
    end
    chk("full ready", 16'(alloc_ready), 16'd0);
    drive(0, 1, 4'h1, 4'hF, 0, 3'd0, 16'h0); tick();
    chk("overflow count", 16'(count), 16'd8);
    chk("overflow tag", 16'(alloc_tag), 16'd0);
    chk("overflow cv", 16'(commit_valid), 16'd0);

    // Full ROB: alloc on the retire edge is refused, accepted on the next.
    drive(0, 0, 4'h0, 4'h0, 1, 3'd0, 16'h0ABC); tick();
    drive(0, 1, 4'h2, 4'hE, 0, 3'd0, 16'h0); tick();
    chk("full-retire cv", 16'(commit_valid), 16'd1);
    chk("full-retire dest", 16'(commit_dest), 16'd1);
    chk("full-retire value", commit_value, 16'h0ABC);
    chk("full-retire count", 16'(count), 16'd7);
    chk("full-retire ready", 16'(alloc_ready), 16'd1);
    chk("wrap tag", 16'(alloc_tag), 16'd0);
    drive(0, 1, 4'h2, 4'hE, 0, 3'd0, 16'h0); tick();
    chk("wrap count", 16'(count), 16'd8);
    chk("wrap tag after", 16'(alloc_tag), 16'd1);
    chk("wrap ready", 16'(alloc_ready), 16'd0);
    chk("wrap cv", 16'(commit_valid), 16'd0);

    // Mid-flight reset: 4 entries, two completed behind a pending head.
    drive(1, 0, 4'h0, 4'h0, 0, 3'd0, 16'h0); tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 4'h1, 4'(i), 0, 3'd0, 16'h0); tick();
    end
    drive(0, 0, 4'h0, 4'h0, 1, 3'd1, 16'h0011); tick();
    drive(0, 0, 4'h0, 4'h0, 1, 3'd3, 16'h0033); tick();
    chk("pre-rst count", 16'(count), 16'd4);
    drive(1, 0, 4'h0, 4'h0, 0, 3'd0, 16'h0); tick();
    chk("rst count", 16'(count), 16'd0);
    chk("rst cv", 16'(commit_valid), 16'd0);
    chk("rst tag", 16'(alloc_tag), 16'd0);
    chk("rst empty", 16'(empty), 16'd1);
    idle(); tick();
    chk("post-rst cv", 16'(commit_valid), 16'd0);
    chk("post-rst count", 16'(count), 16'd0);
    idle(); tick();
    chk("post-rst cv2", 16'(commit_valid), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
